// File: rtl/tx_frame_buffer_if.sv
// Host-write and framer-read signals of tx_frame_buffer.
// master: the host/framer side driving the block; slave: tx_frame_buffer itself.
// Optional TX_ABORT_EN adds abort/aborted.
interface tx_frame_buffer_if #(
  parameter int DEPTH = 256
);
  localparam int FR_W = $clog2(DEPTH) + 1;

  logic [7:0]      wr_data;
  logic            wr_strobe;
  logic            wr_last;
  logic            wr_full;
  logic            overflow;
  logic            overflow_clear;
  logic [FR_W-1:0] frames_ready;
  logic [7:0]      data;
  logic            data_available;
  logic            data_consumed;
  logic            eop;
  logic            flag_fill;
  logic            busy;
`ifdef TX_ABORT_EN
  logic            abort;
  logic            aborted;
`endif

  modport master (
`ifdef TX_ABORT_EN
    output abort,
    input  aborted,
`endif
    output wr_data, wr_strobe, wr_last, overflow_clear, data_consumed,
    input  wr_full, overflow, frames_ready, data, data_available, eop,
           flag_fill, busy
  );

  modport slave (
`ifdef TX_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  wr_data, wr_strobe, wr_last, overflow_clear, data_consumed,
    output wr_full, overflow, frames_ready, data, data_available, eop,
           flag_fill, busy
  );
endinterface

// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer: byte FIFO with frame commit, feeding tx_framer.
// Only committed frames are released; each is sent as preamble (flag_fill),
// bytes on the data_available/data_consumed handshake, then an idle gap.
// Optional feature macro: TX_ABORT_EN (abort input, aborted pulse output).
module tx_frame_buffer #(
  parameter int DEPTH           = 256,
  parameter int PREAMBLE_CYCLES = 64,
  parameter int GAP_CYCLES      = 32
) (
  input  logic               clk,
  input  logic               reset,
  tx_frame_buffer_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int FR_W   = ADDR_W + 1;
  localparam int CMAX   = (PREAMBLE_CYCLES > GAP_CYCLES) ? PREAMBLE_CYCLES : GAP_CYCLES;
  localparam int CNT_W  = $clog2(CMAX + 1);

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [FR_W-1:0] FR_ONE   = {{(FR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PRE, SEND, GAP} state_t;

  // Each entry is {eop, data}.
  logic [8:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] frame_start_q, frame_start_d;
  logic [FR_W-1:0] frames_ready_q, frames_ready_d;
  logic            bad_q, bad_d;
  logic            ovf_q, ovf_d;
  logic            full_q, full_d;
  logic [7:0]      data_q, data_d;
  logic            eop_q, eop_d;
  logic            avail_q, avail_d;
  logic            flag_q, flag_d;
  logic            busy_q, busy_d;
`ifdef TX_ABORT_EN
  logic            skip_q, skip_d;
  logic            aborted_q, aborted_d;
`endif

  logic            we, commit, done, full, can_start;
  logic [ADDR_W:0] nxt_ptr;
  logic [8:0]      rd_word, nxt_word;

  // Occupancy test on pre-update pointers; the read word is always the head.
  assign full     = (wr_ptr_q - rd_ptr_q) == FULL_CNT;
  assign nxt_ptr  = rd_ptr_q + PTR_ONE;
  assign rd_word  = mem[rd_ptr_q[ADDR_W-1:0]];
  assign nxt_word = mem[nxt_ptr[ADDR_W-1:0]];

`ifdef TX_ABORT_EN
  assign can_start = (frames_ready_q != '0) && !skip_q;
`else
  assign can_start = (frames_ready_q != '0);
`endif

  // Next-state logic for the write side, read sequencer and registered outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    frame_start_d  = frame_start_q;
    frames_ready_d = frames_ready_q;
    bad_d          = bad_q;
    ovf_d          = ovf_q;
    data_d         = data_q;
    eop_d          = eop_q;
    avail_d        = avail_q;
    flag_d         = flag_q;
    we             = 1'b0;
    commit         = 1'b0;
    done           = 1'b0;
`ifdef TX_ABORT_EN
    skip_d         = skip_q;
    aborted_d      = 1'b0;
`endif

    // Clear first so a same-cycle overflow set wins.
    if (bus.overflow_clear) ovf_d = 1'b0;

    // Host write. A frame that lost a byte is rewound at its last byte.
    if (bus.wr_strobe) begin
      if (full || bad_q) begin
        if (full) ovf_d = 1'b1;
        if (bus.wr_last) begin
          wr_ptr_d = frame_start_q;
          bad_d    = 1'b0;
        end else if (full) begin
          bad_d = 1'b1;
        end else begin
          // Bad frame with room: keep filling, it is discarded at its end.
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (bus.wr_last) begin
          frame_start_d = wr_ptr_q + PTR_ONE;
          commit        = 1'b1;
        end
      end
    end

`ifdef TX_ABORT_EN
    // Drop the remainder of an aborted frame one entry per cycle.
    if (skip_q) begin
      rd_ptr_d = nxt_ptr;
      skip_d   = !rd_word[8];
    end
    // Abort while not transmitting discards the partial host frame.
    if (bus.abort && (state_q == IDLE || state_q == GAP)) begin
      we            = 1'b0;
      commit        = 1'b0;
      wr_ptr_d      = frame_start_q;
      frame_start_d = frame_start_q;
      bad_d         = 1'b0;
    end
`endif

    // Read-side sequencer.
    unique case (state_q)
      IDLE: begin
        if (can_start) begin
          state_d = PRE;
          cnt_d   = CNT_W'(PREAMBLE_CYCLES - 1);
          flag_d  = 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_d = SEND;
          flag_d  = 1'b0;
          avail_d = 1'b1;
          data_d  = rd_word[7:0];
          eop_d   = rd_word[8];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SEND: begin
        if (bus.data_consumed) begin
          rd_ptr_d = nxt_ptr;
          if (eop_q) begin
            state_d = GAP;
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
            avail_d = 1'b0;
            data_d  = 8'h00;
            eop_d   = 1'b0;
            done    = 1'b1;
          end else begin
            data_d = nxt_word[7:0];
            eop_d  = nxt_word[8];
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase

`ifdef TX_ABORT_EN
    // Abort during preamble or send skips to just past the frame's eop entry.
    if (bus.abort && (state_q == PRE || state_q == SEND)) begin
      state_d   = GAP;
      cnt_d     = CNT_W'(GAP_CYCLES - 1);
      flag_d    = 1'b0;
      avail_d   = 1'b0;
      data_d    = 8'h00;
      eop_d     = 1'b0;
      done      = 1'b1;
      aborted_d = 1'b1;
      rd_ptr_d  = nxt_ptr;
      skip_d    = !rd_word[8];
    end
`endif

    // A commit and a frame retirement in the same cycle cancel out.
    unique case ({commit, done})
      2'b10:   frames_ready_d = frames_ready_q + FR_ONE;
      2'b01:   frames_ready_d = frames_ready_q - FR_ONE;
      default: frames_ready_d = frames_ready_q;
    endcase

    busy_d = (state_d != IDLE);
    full_d = (wr_ptr_d - rd_ptr_d) == FULL_CNT;
  end

  // State and output registers; reset empties the FIFO and drops partial frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      frame_start_q  <= '0;
      frames_ready_q <= '0;
      bad_q          <= 1'b0;
      ovf_q          <= 1'b0;
      full_q         <= 1'b0;
      data_q         <= 8'h00;
      eop_q          <= 1'b0;
      avail_q        <= 1'b0;
      flag_q         <= 1'b0;
      busy_q         <= 1'b0;
`ifdef TX_ABORT_EN
      skip_q         <= 1'b0;
      aborted_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      frame_start_q  <= frame_start_d;
      frames_ready_q <= frames_ready_d;
      bad_q          <= bad_d;
      ovf_q          <= ovf_d;
      full_q         <= full_d;
      data_q         <= data_d;
      eop_q          <= eop_d;
      avail_q        <= avail_d;
      flag_q         <= flag_d;
      busy_q         <= busy_d;
`ifdef TX_ABORT_EN
      skip_q         <= skip_d;
      aborted_q      <= aborted_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[ADDR_W-1:0]] <= {bus.wr_last, bus.wr_data};
  end

  assign bus.wr_full        = full_q;
  assign bus.overflow       = ovf_q;
  assign bus.frames_ready   = frames_ready_q;
  assign bus.data           = data_q;
  assign bus.data_available = avail_q;
  assign bus.eop            = eop_q;
  assign bus.flag_fill      = flag_q;
  assign bus.busy           = busy_q;
`ifdef TX_ABORT_EN
  assign bus.aborted        = aborted_q;
`endif
endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer (DEPTH=4, 64-cycle preamble, 32-cycle gap).
// Written bytes of committed frames go into a scoreboard queue and are
// popped as the framer side consumes them.
module tb_tx_frame_buffer;
  localparam int DEPTH = 4;
  localparam int PRE   = 64;
  localparam int GAP   = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tx_frame_buffer_if #(.DEPTH(DEPTH)) bus ();

  tx_frame_buffer #(.DEPTH(DEPTH), .PREAMBLE_CYCLES(PRE), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] sb[$];
  logic [8:0] pend[$];

  // Tasks are entered at a negedge and return at a negedge.
  task automatic wr(input logic [7:0] d, input bit last, input bit keep);
    bus.wr_data   = d;
    bus.wr_strobe = 1'b1;
    bus.wr_last   = last;
    pend.push_back({last, d});
    @(negedge clk);
    bus.wr_strobe = 1'b0;
    bus.wr_last   = 1'b0;
    if (last) begin
      if (keep) foreach (pend[i]) sb.push_back(pend[i]);
      pend.delete();
    end
  endtask

  task automatic take_byte(input bit with_commit, input logic [7:0] cbyte, output bit was_eop);
    int n = 0;
    logic [8:0] exp;
    was_eop = 1'b1;
    while (bus.data_available !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.data_available !== 1'b1) begin
      bad++;
      $display("FAIL avail_wait got=%b want=1", bus.data_available);
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_empty got=%h want=nothing", {bus.eop, bus.data});
      return;
    end
    exp = sb.pop_front();
    total++;
    if ({bus.eop, bus.data} !== exp) begin
      bad++;
      $display("FAIL byte got=%h want=%h", {bus.eop, bus.data}, exp);
    end
    was_eop = exp[8];
    bus.data_consumed = 1'b1;
    if (with_commit) begin
      bus.wr_data   = cbyte;
      bus.wr_strobe = 1'b1;
      bus.wr_last   = 1'b1;
      pend.push_back({1'b1, cbyte});
    end
    @(negedge clk);
    bus.data_consumed = 1'b0;
    bus.wr_strobe     = 1'b0;
    bus.wr_last       = 1'b0;
    if (with_commit) begin
      foreach (pend[i]) sb.push_back(pend[i]);
      pend.delete();
    end
  endtask

  task automatic consume_frame();
    bit e = 1'b0;
    for (int i = 0; i < 8 && !e; i++) begin
      take_byte(1'b0, 8'h00, e);
      if (!e) begin
        total++;
        if (bus.data_available !== 1'b1) begin
          bad++;
          $display("FAIL avail_between got=%b want=1", bus.data_available);
        end
      end
    end
    total++;
    if (bus.data_available !== 1'b0) begin
      bad++;
      $display("FAIL avail_after_eop got=%b want=0", bus.data_available);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_wait got=%b want=0", bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.wr_data = 8'h00; bus.wr_strobe = 1'b0; bus.wr_last = 1'b0;
    bus.overflow_clear = 1'b0; bus.data_consumed = 1'b0;
`ifdef TX_ABORT_EN
    bus.abort = 1'b0;
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.data_available, bus.flag_fill, bus.busy, bus.eop, bus.data,
         bus.frames_ready, bus.wr_full, bus.overflow} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b,%b,%b,%b,%h,%0d,%b,%b want=all zero",
               bus.data_available, bus.flag_fill, bus.busy, bus.eop, bus.data,
               bus.frames_ready, bus.wr_full, bus.overflow);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n = 0;
    wr(8'h53, 1'b0, 1'b1);
    wr(8'h41, 1'b0, 1'b1);
    wr(8'h10, 1'b1, 1'b1);
    total++;
    if (bus.frames_ready !== 3'd1) begin
      bad++;
      $display("FAIL basic_ready got=%0d want=1", bus.frames_ready);
    end
    while (bus.flag_fill !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (bus.flag_fill === 1'b1 && n < 500) begin @(negedge clk); n++; end
    total++;
    if (n != PRE) begin
      bad++;
      $display("FAIL preamble_len got=%0d want=%0d", n, PRE);
    end
    consume_frame();
    total++;
    if (bus.frames_ready !== 3'd0) begin
      bad++;
      $display("FAIL basic_ready_after got=%0d want=0", bus.frames_ready);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n != GAP) begin
      bad++;
      $display("FAIL gap_busy got=%0d want=%0d", n, GAP);
    end
  endtask

  task automatic test_no_commit();
    int hi = 0;
    int n = 0;
    wr(8'hA1, 1'b0, 1'b1);
    wr(8'hA2, 1'b0, 1'b1);
    total++;
    if (bus.frames_ready !== 3'd0) begin
      bad++;
      $display("FAIL nocommit_ready got=%0d want=0", bus.frames_ready);
    end
    repeat (1000) begin
      @(negedge clk);
      if (bus.flag_fill !== 1'b0) hi++;
    end
    total++;
    if (hi != 0) begin
      bad++;
      $display("FAIL nocommit_flag got=%0d want=0", hi);
    end
    wr(8'hA3, 1'b1, 1'b1);
    while (bus.flag_fill !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (bus.flag_fill !== 1'b1) begin
      bad++;
      $display("FAIL nocommit_start got=%b want=1", bus.flag_fill);
    end
    consume_frame();
    wait_idle();
  endtask

  task automatic test_overflow();
    wr(8'h01, 1'b0, 1'b0);
    wr(8'h02, 1'b0, 1'b0);
    wr(8'h03, 1'b0, 1'b0);
    wr(8'h04, 1'b0, 1'b0);
    total++;
    if (bus.wr_full !== 1'b1) begin
      bad++;
      $display("FAIL full_flag got=%b want=1", bus.wr_full);
    end
    wr(8'h05, 1'b1, 1'b0);
    total++;
    if ({bus.overflow, bus.frames_ready, bus.wr_full} !== {1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL ovf_state got=ovf%b ready%0d full%b want=ovf1 ready0 full0",
               bus.overflow, bus.frames_ready, bus.wr_full);
    end
    repeat (5) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ovf_no_start got=%b want=0", bus.busy);
    end
    wr(8'h77, 1'b0, 1'b1);
    wr(8'h78, 1'b1, 1'b1);
    consume_frame();
    wait_idle();
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", bus.overflow);
    end
    bus.overflow_clear = 1'b1;
    @(negedge clk);
    bus.overflow_clear = 1'b0;
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b want=0", bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    wr(8'hB0, 1'b0, 1'b1);
    wr(8'hB1, 1'b1, 1'b1);
    wr(8'hC0, 1'b0, 1'b1);
    wr(8'hC1, 1'b1, 1'b1);
    total++;
    if (bus.frames_ready !== 3'd2) begin
      bad++;
      $display("FAIL b2b_ready2 got=%0d want=2", bus.frames_ready);
    end
    consume_frame();
    total++;
    if (bus.frames_ready !== 3'd1) begin
      bad++;
      $display("FAIL b2b_ready1 got=%0d want=1", bus.frames_ready);
    end
    while (bus.flag_fill !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (n < GAP || n >= 200) begin
      bad++;
      $display("FAIL b2b_gap got=%0d want>=%0d", n, GAP);
    end
    consume_frame();
    total++;
    if (bus.frames_ready !== 3'd0) begin
      bad++;
      $display("FAIL b2b_ready0 got=%0d want=0", bus.frames_ready);
    end
    wait_idle();
  endtask

  task automatic test_commit_on_eop();
    bit e;
    wr(8'hD0, 1'b0, 1'b1);
    wr(8'hD1, 1'b1, 1'b1);
    wr(8'hE0, 1'b0, 1'b1);
    take_byte(1'b0, 8'h00, e);
    take_byte(1'b1, 8'hE1, e);
    total++;
    if ({bus.frames_ready, bus.data_available} !== {3'd1, 1'b0}) begin
      bad++;
      $display("FAIL coe_ready got=ready%0d avail%b want=ready1 avail0",
               bus.frames_ready, bus.data_available);
    end
    consume_frame();
    total++;
    if (bus.frames_ready !== 3'd0) begin
      bad++;
      $display("FAIL coe_ready0 got=%0d want=0", bus.frames_ready);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_send();
    bit e;
    int hi = 0;
    wr(8'hF0, 1'b0, 1'b1);
    wr(8'hF1, 1'b0, 1'b1);
    wr(8'hF2, 1'b1, 1'b1);
    take_byte(1'b0, 8'h00, e);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.data_available, bus.flag_fill, bus.busy, bus.eop, bus.data,
         bus.frames_ready, bus.wr_full, bus.overflow} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%b,%b,%b,%b,%h,%0d want=all zero",
               bus.data_available, bus.flag_fill, bus.busy, bus.eop, bus.data,
               bus.frames_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    pend.delete();
    repeat (200) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.flag_fill !== 1'b0 || bus.data_available !== 1'b0) hi++;
    end
    total++;
    if (hi != 0 || bus.frames_ready !== 3'd0) begin
      bad++;
      $display("FAIL post_reset_idle got=active%0d ready%0d want=active0 ready0",
               hi, bus.frames_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_commit();
    test_overflow();
    test_back_to_back();
    test_commit_on_eop();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_frame_buffer.md
Name: tx_frame_buffer

Overview:
Byte FIFO and frame sequencer directly upstream of tx_framer. The host side writes frame bytes and marks the last one. Only complete, committed frames are released to the framer. For each frame the block drives a flag-fill preamble, then presents bytes on the data/data_available/data_consumed/eop handshake, then enforces an inter-frame gap.

Parameters:
DEPTH, 256, FIFO entries (power of 2, ≥4); each entry is 8 data bits plus 1 eop bit
PREAMBLE_CYCLES, 64, clk cycles flag_fill is held high before the first byte of each frame (≥1)
GAP_CYCLES, 32, clk cycles of idle after the eop byte is consumed before the next frame may start (≥1)

Ports:
clk  input  1  single clock for the whole block
reset  input  1  asynchronous, active-high reset
wr_data  input  8  host byte
wr_strobe  input  1  write wr_data this cycle
wr_last  input  1  qualifies wr_strobe: byte is the last of its frame, commit frame
wr_full  output  1  FIFO holds DEPTH entries
overflow  output  1  sticky: a byte was dropped
overflow_clear  input  1  clears overflow
frames_ready  output  $clog2(DEPTH)+1  committed frames not yet fully consumed
data  output  8  byte to framer
data_available  output  1  data is valid for the framer
data_consumed  input  1  one-cycle pulse from the framer: current byte taken
eop  output  1  data is the last byte of the frame
flag_fill  output  1  framer sends flags (preamble)
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset: pointers, frame-start pointer, frames_ready, counters = 0; state IDLE; data_available, eop, flag_fill, busy, overflow, wr_full = 0; data = 8'h00.
- Reset mid-frame discards all FIFO contents and any partial frame.
- Pointers: rd_ptr, wr_ptr, and frame_start are ADDR_W+1 bits wide and wrap modulo 2*DEPTH. full when wr_ptr - rd_ptr == DEPTH.
- Write: wr_strobe && !full stores {wr_last, wr_data} at wr_ptr and increments wr_ptr.
- Write with wr_last and a good frame: frame_start <= wr_ptr+1 and frames_ready++ (effective next cycle).
- wr_strobe while full: byte dropped, overflow <= 1, and the in-progress frame is marked bad.
- A subsequent wr_strobe&&wr_last on a bad frame rewinds wr_ptr to frame_start, clears the bad mark, and does not commit. The last byte is not stored.
- overflow_clear has priority below a same-cycle set; the set wins.
- Uncommitted bytes are never visible to the read side.
- States: IDLE -> PRE when frames_ready>0. PRE holds flag_fill=1 for exactly PREAMBLE_CYCLES cycles -> SEND. SEND -> GAP on a consumed eop byte. GAP waits GAP_CYCLES -> IDLE.
- SEND, output drive: data_available=1, data=fifo[rd_ptr].data, eop=fifo[rd_ptr].eop, all registered.
- SEND, consume: data_consumed increments rd_ptr; the new byte is presented the following cycle. data_available stays high between bytes.
- SEND, eop consumed: data_available deasserts the cycle after, frames_ready--, -> GAP.
- data_consumed outside SEND is ignored.
- A commit and an eop consumption in the same cycle leave frames_ready unchanged.
- flag_fill is 0 in all states except PRE. data_available is 0 in all states except SEND.
- A write landing exactly when the buffer becomes non-full is accepted. Full/empty are evaluated on pre-update pointers; read and write in the same cycle are both honoured.

Optional Feature:
TX_ABORT_EN: adds input abort (1 bit) and output aborted (1-cycle pulse).
- abort in PRE or SEND: rd_ptr advances past the current frame's eop entry, frames_ready--, data_available/flag_fill drop next cycle, -> GAP, aborted pulses.
- abort in IDLE or GAP: the partial host-side frame is discarded (wr_ptr <= frame_start), no pulse.
- Without the macro: neither port exists and behaviour is as above.

Test Plan:
- Reset, then write 3 bytes 0x53,0x41,0x10 (last on 0x10) -> flag_fill high exactly 64 cycles. Then data=0x53 with data_available=1 and eop=0; pulses give 0x41, then 0x10 with eop=1. After the final pulse data_available=0, frames_ready 1→0, and busy stays high 32 more cycles.
- Write 2 bytes without wr_last -> frames_ready=0, flag_fill stays 0 for 1000 cycles. Then write with wr_last -> preamble starts.
- DEPTH=4: write 5 bytes, last with wr_last -> overflow=1, frames_ready=0, FIFO empty. Next 2-byte frame transmits correctly. overflow_clear -> 0.
- Queue two frames back-to-back -> two preambles separated by ≥32-cycle gap, frames_ready 2→1→0.
- Commit a frame on the same cycle as the eop of the previous frame is consumed -> frames_ready unchanged, next frame follows after the gap.
- Assert reset mid-SEND -> all outputs 0 immediately (asynchronous). After release the block stays IDLE with frames_ready=0.
